// File: rtl/uart_tx_cfg_if.sv
// uart_tx_cfg_if: valid/ready word handshake between upstream logic and the UART transmitter
interface uart_tx_cfg_if #(parameter int WORD_SIZE = 8);
  logic Tx_Valid;
  logic Tx_Ready;
  logic [WORD_SIZE-1:0] Tx_Data;
  modport master(output Tx_Valid, output Tx_Data, input Tx_Ready);
  modport slave(input Tx_Valid, input Tx_Data, output Tx_Ready);
endinterface

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: configurable UART transmitter with internal bit timing, parity and 1/2 stop bits
module uart_tx_cfg #(
  parameter int CLKS_PER_BIT = 16,
  parameter int WORD_SIZE = 8,
  parameter int PARITY = 0,
  parameter int STOP_SIZE = 1
) (
  input  logic Clk_Tx,
  input  logic Rst_Tx,
  uart_tx_cfg_if.slave tx,
  output logic Tx_Serial,
  output logic Tx_Busy,
  output logic Tx_Done
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int WW = $clog2(WORD_SIZE);
  if (CLKS_PER_BIT < 2 || WORD_SIZE < 5 || WORD_SIZE > 9 || PARITY < 0 || PARITY > 2 ||
      (STOP_SIZE != 1 && STOP_SIZE != 2)) begin : g_bad
    $error("uart_tx_cfg: illegal parameter combination");
  end
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
  state_t state;
  logic [BW-1:0] baud_cnt;
  logic [WW-1:0] bit_cnt;
  logic stop_cnt;
  logic [WORD_SIZE-1:0] shift_r;
  logic par_r;
  logic bit_end, last_stop, accept;
  assign bit_end = baud_cnt == BW'(CLKS_PER_BIT - 1);
  assign last_stop = state == S_STOP && bit_end && stop_cnt == 1'(STOP_SIZE - 1);
  assign tx.Tx_Ready = !Rst_Tx && (state == S_IDLE || last_stop);
  assign accept = tx.Tx_Valid && tx.Tx_Ready;
  always_ff @(posedge Clk_Tx) begin
    if (Rst_Tx) begin
      state <= S_IDLE;
      baud_cnt <= '0;
      bit_cnt <= '0;
      stop_cnt <= 1'b0;
      shift_r <= '0;
      par_r <= 1'b0;
      Tx_Serial <= 1'b1;
      Tx_Busy <= 1'b0;
      Tx_Done <= 1'b0;
    end else begin
      Tx_Done <= last_stop;
      baud_cnt <= (state == S_IDLE || bit_end) ? '0 : baud_cnt + 1'b1;
      if (accept) begin
        // parity is fixed at capture so later shifting cannot disturb it
        shift_r <= tx.Tx_Data;
        par_r <= (PARITY == 2) ? ~^tx.Tx_Data : ^tx.Tx_Data;
        state <= S_START;
        bit_cnt <= '0;
        stop_cnt <= 1'b0;
        Tx_Serial <= 1'b0;
        Tx_Busy <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            Tx_Serial <= 1'b1;
            Tx_Busy <= 1'b0;
          end
          S_START: if (bit_end) begin
            state <= S_DATA;
            Tx_Serial <= shift_r[0];
          end
          S_DATA: if (bit_end) begin
            shift_r <= shift_r >> 1;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == WW'(WORD_SIZE - 1)) begin
              state <= (PARITY != 0) ? S_PARITY : S_STOP;
              Tx_Serial <= (PARITY != 0) ? par_r : 1'b1;
            end else begin
              Tx_Serial <= shift_r[1];
            end
          end
          S_PARITY: if (bit_end) begin
            state <= S_STOP;
            Tx_Serial <= 1'b1;
          end
          S_STOP: if (bit_end) begin
            stop_cnt <= stop_cnt + 1'b1;
            if (last_stop) begin
              state <= S_IDLE;
              Tx_Busy <= 1'b0;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: directed checks of four transmitter configurations (8N1, 7E1, 7O1, 8N2)
module tb_uart_tx_cfg;
  localparam int CPB = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] v = '0;
  logic [8:0] dat [4];
  logic [3:0] ser, busy, done, rdy;
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  uart_tx_cfg_if #(.WORD_SIZE(8)) i0 ();
  uart_tx_cfg_if #(.WORD_SIZE(7)) i1 ();
  uart_tx_cfg_if #(.WORD_SIZE(7)) i2 ();
  uart_tx_cfg_if #(.WORD_SIZE(8)) i3 ();
  assign i0.Tx_Valid = v[0];
  assign i1.Tx_Valid = v[1];
  assign i2.Tx_Valid = v[2];
  assign i3.Tx_Valid = v[3];
  assign i0.Tx_Data = dat[0][7:0];
  assign i1.Tx_Data = dat[1][6:0];
  assign i2.Tx_Data = dat[2][6:0];
  assign i3.Tx_Data = dat[3][7:0];
  assign rdy = {i3.Tx_Ready, i2.Tx_Ready, i1.Tx_Ready, i0.Tx_Ready};
  uart_tx_cfg #(.CLKS_PER_BIT(CPB), .WORD_SIZE(8), .PARITY(0), .STOP_SIZE(1)) d0 (
    .Clk_Tx(clk), .Rst_Tx(rst), .tx(i0), .Tx_Serial(ser[0]), .Tx_Busy(busy[0]), .Tx_Done(done[0]));
  uart_tx_cfg #(.CLKS_PER_BIT(CPB), .WORD_SIZE(7), .PARITY(1), .STOP_SIZE(1)) d1 (
    .Clk_Tx(clk), .Rst_Tx(rst), .tx(i1), .Tx_Serial(ser[1]), .Tx_Busy(busy[1]), .Tx_Done(done[1]));
  uart_tx_cfg #(.CLKS_PER_BIT(CPB), .WORD_SIZE(7), .PARITY(2), .STOP_SIZE(1)) d2 (
    .Clk_Tx(clk), .Rst_Tx(rst), .tx(i2), .Tx_Serial(ser[2]), .Tx_Busy(busy[2]), .Tx_Done(done[2]));
  uart_tx_cfg #(.CLKS_PER_BIT(CPB), .WORD_SIZE(8), .PARITY(0), .STOP_SIZE(2)) d3 (
    .Clk_Tx(clk), .Rst_Tx(rst), .tx(i3), .Tx_Serial(ser[3]), .Tx_Busy(busy[3]), .Tx_Done(done[3]));
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // bits: transmitted sequence, bit 0 first; two = second word w1 sent back-to-back
  task automatic run(input int u, input string tag, input logic [8:0] w0, input logic [8:0] w1,
                     input bit two, input logic [31:0] bits, input int nb);
    int n = nb * CPB;
    int fl = two ? n / 2 : n;
    logic [127:0] s_o = '0, s_e = '0, r_o = '0, r_e = '0, d_o = '0, d_e = '0;
    logic b_ok = 1'b1;
    for (int k = 0; k < n; k++) begin
      s_e[k] = bits[k / CPB];
      r_e[k] = (k % fl) == fl - 1;
      d_e[k] = two && k == fl;
    end
    @(negedge clk);
    chk({tag, "_rdy0"}, 128'(rdy[u]), 128'd1);
    v[u] = 1'b1;
    dat[u] = w0;
    @(negedge clk);
    dat[u] = two ? w1 : ~w0;
    v[u] = two;
    for (int k = 0; k < n; k++) begin
      s_o[k] = ser[u];
      r_o[k] = rdy[u];
      d_o[k] = done[u];
      b_ok &= busy[u];
      if (!two && k == 10) v[u] = 1'b1;
      if (!two && k == 11) v[u] = 1'b0;
      if (two && k == fl) v[u] = 1'b0;
      @(negedge clk);
    end
    chk({tag, "_ser"}, s_o, s_e);
    chk({tag, "_rdy"}, r_o, r_e);
    chk({tag, "_done_mid"}, d_o, d_e);
    chk({tag, "_busy"}, 128'(b_ok), 128'd1);
    chk({tag, "_done"}, 128'({done[u], busy[u], ser[u]}), 128'b101);
    @(negedge clk);
    chk({tag, "_idle"}, 128'({done[u], busy[u], ser[u], rdy[u]}), 128'b0011);
  endtask
  initial begin
    logic seen;
    for (int i = 0; i < 4; i++) dat[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_out", 128'({ser, busy, done, rdy}), 128'hF000);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rel", 128'({ser, busy, done, rdy}), 128'hF00F);
    run(0, "a5_8n1", 9'hA5, 9'h0, 1'b0, {1'b1, 8'hA5, 1'b0}, 10);
    run(1, "41_7e1", 9'h41, 9'h0, 1'b0, {1'b1, 1'b0, 7'h41, 1'b0}, 10);
    run(2, "41_7o1", 9'h41, 9'h0, 1'b0, {1'b1, 1'b1, 7'h41, 1'b0}, 10);
    run(3, "00_8n2", 9'h00, 9'h0, 1'b0, {2'b11, 8'h00, 1'b0}, 11);
    run(0, "b2b", 9'h55, 9'h3C, 1'b1, {1'b1, 8'h3C, 1'b0, 1'b1, 8'h55, 1'b0}, 20);
    @(negedge clk);
    v[0] = 1'b1;
    dat[0] = 9'h00;
    @(negedge clk);
    v[0] = 1'b0;
    repeat (9) @(negedge clk);
    chk("mid_data", 128'({ser[0], busy[0]}), 128'b01);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst", 128'({ser[0], busy[0], done[0], rdy[0]}), 128'b1000);
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      seen |= done[0] | busy[0] | ~ser[0];
    end
    chk("post_rst_quiet", 128'(seen), 128'd0);
    run(0, "ff_8n1", 9'hFF, 9'h0, 1'b0, {1'b1, 8'hFF, 1'b0}, 10);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
